// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: iterative signed multiply / divide, one iteration per
// falling edge of clock, operating on operand magnitudes with the sign
// applied at the end.
//
// Build option: define MULTDIV_OVF_DETECT_EN to keep the full 2*WIDTH-bit
// product and flag multiplies that do not fit in WIDTH signed bits. Without
// it only the low WIDTH product bits are kept and multiply never flags.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT / ctrl_DIV
// RUN   | WIDTH shift-add (mul) or restoring shift-subtract (div) iterations
// FIX   | apply result sign, compute exception; a zero divisor lingers one
//       | extra edge here so its completion lands two edges after the start
// DONE  | data_resultRDY high for this cycle; a new request may start here

module multdiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clr,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

`ifdef MULTDIV_OVF_DETECT_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  localparam int            CW        = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    a_reg;     // multiplicand (shifts left) / dividend becoming quotient
  logic [WIDTH-1:0] b_reg;     // multiplier (shifts right) / divisor magnitude
  logic [PW-1:0]    acc;       // product accumulator / partial remainder
  logic             op_div;
  logic             neg;
  logic             dz;
  logic             fix_hold;

  logic             start, start_div, start_dz;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] quo, prod;
  logic             ovf;

  // Request decode, operand magnitudes and one divide step, all combinational.
  always_comb begin
    start     = ((state == IDLE) || (state == DONE)) && (ctrl_MULT || ctrl_DIV);
    start_div = ctrl_DIV && !ctrl_MULT;
    start_dz  = start_div && (data_operandB == '0);
    a_mag     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    b_mag     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    rem_sh    = {acc[WIDTH-1:0], a_reg[WIDTH-1]};
    rem_ge    = rem_sh >= {1'b0, b_reg};
    rem_diff  = rem_sh[WIDTH-1:0] - b_reg;
    quo       = a_reg[WIDTH-1:0];
    prod      = acc[WIDTH-1:0];
  end

`ifdef MULTDIV_OVF_DETECT_EN
  logic [WIDTH:0] prod_hi;
  // Product overflows when the bits above the result's sign bit are not a pure sign extension.
  always_comb begin
    prod_hi = (WIDTH + 1)'((neg ? -acc : acc) >> (WIDTH - 1));
    ovf     = !((&prod_hi) || !(|prod_hi));
  end
`else
  assign ovf = 1'b0;
`endif

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = start ? (start_dz ? FIX : RUN) : IDLE;
      RUN:        if (cnt == LAST_ITER) state_nxt = FIX;
      FIX:        if (!fix_hold) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  // State, operand latch, iteration datapath and result registers.
  always_ff @(negedge clock or posedge clr) begin
    if (clr) begin
      state          <= IDLE;
      cnt            <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      acc            <= '0;
      op_div         <= 1'b0;
      neg            <= 1'b0;
      dz             <= 1'b0;
      fix_hold       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        a_reg    <= PW'(a_mag);
        b_reg    <= b_mag;
        acc      <= '0;
        cnt      <= '0;
        op_div   <= start_div;
        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dz       <= start_dz;
        fix_hold <= start_dz;
      end else begin
        case (state)
          RUN: begin
            cnt <= cnt + 1'b1;
            if (op_div) begin
              acc               <= PW'(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]);
              a_reg[WIDTH-1:0]  <= {a_reg[WIDTH-2:0], rem_ge};
            end else begin
              if (b_reg[0]) acc <= acc + a_reg;
              a_reg <= a_reg << 1;
              b_reg <= b_reg >> 1;
            end
          end
          FIX: begin
            if (fix_hold) begin
              fix_hold <= 1'b0;
            end else if (op_div) begin
              data_result    <= dz ? '0 : (neg ? -quo : quo);
              data_exception <= dz;
            end else begin
              data_result    <= neg ? -prod : prod;
              data_exception <= ovf;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy           = (state == RUN) || (state == FIX);
  assign data_resultRDY = (state == DONE);

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: an edge-counting arithmetic model checked
// against the DUT every cycle, plus directed operations with literal results.
module tb_multdiv_sequencer;
  localparam int W = 32;
`ifdef MULTDIV_OVF_DETECT_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic         clock = 1'b1;
  logic         clr;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ctrl_MULT;
  logic         ctrl_DIV;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int checks = 0;
  int errors = 0;

  multdiv_sequencer #(.WIDTH(W)) dut (
    .clock(clock),
    .clr(clr),
    .data_operandA(data_operandA),
    .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT),
    .ctrl_DIV(ctrl_DIV),
    .data_result(data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected result of one operation from plain signed arithmetic.
  task automatic expect_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic is_div,
                           output logic [W-1:0] r, output logic e);
    longint sa, sb, p, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (is_div) begin
      if (sb == 0) begin
        r = '0;
        e = 1'b1;
      end else begin
        q = sa / sb;
        r = q[W-1:0];
        e = 1'b0;
      end
    end else begin
      p = sa * sb;
      r = p[W-1:0];
      e = OVF_EN && (p != longint'($signed(p[W-1:0])));
    end
  endtask

  // Model: edges remaining until completion; results published when it reaches zero.
  int           m_left = 0;
  logic         m_rdy = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_exc = 1'b0;
  logic [W-1:0] p_res = '0;
  logic         p_exc = 1'b0;

  always @(negedge clock or posedge clr) begin
    if (clr) begin
      m_left = 0;
      m_rdy  = 1'b0;
      m_res  = '0;
      m_exc  = 1'b0;
    end else begin
      m_rdy = 1'b0;
      if (m_left == 0) begin
        if (ctrl_MULT || ctrl_DIV) begin
          expect_op(data_operandA, data_operandB, ctrl_DIV && !ctrl_MULT, p_res, p_exc);
          m_left = (ctrl_DIV && !ctrl_MULT && data_operandB == '0) ? 2 : W + 1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_rdy = 1'b1;
          m_res = p_res;
          m_exc = p_exc;
        end
      end
    end
  end

  // Compare DUT with model every cycle, mid-way between falling edges.
  always @(posedge clock) begin
    chk("cyc_busy", W'(busy), W'(m_left > 0));
    chk("cyc_rdy", W'(data_resultRDY), W'(m_rdy));
    chk("cyc_result", data_result, m_res);
    chk("cyc_exception", W'(data_exception), W'(m_exc));
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic m, input logic d,
                       input logic [W-1:0] er, input logic ee, input int elat, input string name);
    int   n;
    logic seen;
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(negedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clock);
      #1;
      n++;
      seen = data_resultRDY;
    end
    chk({name, "_latency"}, W'(n), W'(elat));
    chk({name, "_result"}, data_result, er);
    chk({name, "_exception"}, W'(data_exception), W'(ee));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           n;
    logic         seen;
    int           rdy_seen;
    logic [W-1:0] held;
    clr           = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    #1 clr = 1'b1;
    #1;
    chk("rst_result", data_result, '0);
    chk("rst_exception", W'(data_exception), '0);
    chk("rst_rdy", W'(data_resultRDY), '0);
    chk("rst_busy", W'(busy), '0);
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 clr = 1'b0;

    do_op(32'd7,        32'hFFFFFFFD, 1'b1, 1'b0, 32'hFFFFFFEB, 1'b0,   33, "mul_7_m3");
    do_op(32'hFFFFFF9C, 32'd7,        1'b0, 1'b1, 32'hFFFFFFF2, 1'b0,   33, "div_m100_7");
    do_op(32'hFFFFFF9C, 32'd0,        1'b0, 1'b1, 32'h00000000, 1'b1,    2, "div_by_zero");
    do_op(32'h40000000, 32'd4,        1'b1, 1'b0, 32'h00000000, OVF_EN, 33, "mul_2p30_4");
    do_op(32'd6,        32'd3,        1'b1, 1'b1, 32'd18,       1'b0,   33, "both_ctrl");
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0,   33, "div_min_m1");
    do_op(32'd100,      32'hFFFFFFF9, 1'b0, 1'b1, 32'hFFFFFFF2, 1'b0,   33, "div_100_m7");
    do_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b0, 1'b1, 32'd14,       1'b0,   33, "div_m100_m7");
    do_op(32'd5,        32'd7,        1'b0, 1'b1, 32'd0,        1'b0,   33, "div_5_7");
    do_op(32'd7,        32'd0,        1'b0, 1'b1, 32'd0,        1'b1,    2, "div_7_0");
    do_op(32'h7FFFFFFF, 32'd1,        1'b0, 1'b1, 32'h7FFFFFFF, 1'b0,   33, "div_max_1");
    do_op(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 1'b0, 32'd1,        OVF_EN, 33, "mul_max_max");
    do_op(32'h80000000, 32'd1,        1'b1, 1'b0, 32'h80000000, 1'b0,   33, "mul_min_1");
    do_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h80000000, OVF_EN, 33, "mul_min_m1");
    do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'd1,        1'b0,   33, "mul_m1_m1");
    do_op(32'd1000,     32'hFFFFFFCE, 1'b1, 1'b0, 32'hFFFF3CB0, 1'b0,   33, "mul_1000_m50");

    held = data_result;
    repeat (5) @(negedge clock);
    #1;
    chk("hold_result", data_result, 32'hFFFF3CB0);
    chk("hold_busy", W'(busy), '0);

    // Divide request during a multiply's RUN must be ignored.
    data_operandA = 32'd3;
    data_operandB = 32'hFFFFFFFB;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    #1 ctrl_MULT = 1'b0;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      if (n == 4) begin
        ctrl_DIV      = 1'b1;
        data_operandA = 32'd100;
        data_operandB = 32'd0;
      end
      if (n == 5) ctrl_DIV = 1'b0;
      @(negedge clock);
      #1;
      n++;
      seen = data_resultRDY;
    end
    chk("ignore_div_latency", W'(n), W'(33));
    chk("ignore_div_result", data_result, 32'hFFFFFFF1);
    do_op(32'd9, 32'd9, 1'b1, 1'b0, 32'd81, 1'b0, 33, "b2b_mul");

    // Reset in the middle of a multiply.
    data_operandA = 32'd5;
    data_operandB = 32'd9;
    ctrl_MULT     = 1'b1;
    @(negedge clock);
    #1 ctrl_MULT = 1'b0;
    repeat (10) @(negedge clock);
    #2 clr = 1'b1;
    #1;
    chk("abort_result", data_result, '0);
    chk("abort_exception", W'(data_exception), '0);
    chk("abort_rdy", W'(data_resultRDY), '0);
    chk("abort_busy", W'(busy), '0);
    @(negedge clock);
    @(posedge clock);
    #1 clr = 1'b0;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      #1;
      if (data_resultRDY) rdy_seen++;
    end
    chk("abort_no_rdy", W'(rdy_seen), '0);

    do_op(32'd7, 32'hFFFFFFFD, 1'b1, 1'b0, 32'hFFFFFFEB, 1'b0, 33, "post_abort_mul");

    if (held !== data_result) begin
      chk("post_abort_changed", data_result, 32'hFFFFFFEB);
    end

    @(posedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multdiv_sequencer.md
MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The module SHALL have port clock, input, 1 bit: the system clock; all state updates occur on its falling edge.
REQ-003 The module SHALL have port clr, input, 1 bit: reset, asynchronous, active-high.
REQ-004 The module SHALL have port data_operandA, input, WIDTH bits: signed multiplicand or dividend.
REQ-005 The module SHALL have port data_operandB, input, WIDTH bits: signed multiplier or divisor.
REQ-006 The module SHALL have port ctrl_MULT, input, 1 bit: start-multiply request, sampled at a falling edge.
REQ-007 The module SHALL have port ctrl_DIV, input, 1 bit: start-divide request, sampled at a falling edge.
REQ-008 The module SHALL have port data_result, output, WIDTH bits: the registered result.
REQ-009 The module SHALL have port data_exception, output, 1 bit: the exception flag, valid while data_resultRDY is high.
REQ-010 The module SHALL have port data_resultRDY, output, 1 bit: a one-cycle completion pulse.
REQ-011 The module SHALL have port busy, output, 1 bit: high while an operation is in progress.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, RUN, FIX and DONE.
REQ-013 In IDLE or DONE, a falling edge with ctrl_MULT or ctrl_DIV high SHALL latch both operands and the operation type, clear the iteration counter and enter RUN; this edge is start edge E0.
REQ-014 If ctrl_MULT and ctrl_DIV are both high at a start edge, the operation SHALL be multiply.
REQ-015 ctrl_MULT and ctrl_DIV SHALL be ignored in RUN and FIX.
REQ-016 RUN SHALL execute exactly WIDTH iterations, one per falling edge: unsigned shift-add for multiply, restoring shift-subtract for divide, both on operand magnitudes.
REQ-017 FIX SHALL take one edge: it SHALL apply the result sign (XOR of the operand signs) and compute data_exception.
REQ-018 data_resultRDY SHALL be high for exactly one cycle, following edge E0+WIDTH+1, in state DONE.
REQ-019 DONE SHALL return to IDLE on the next edge unless a new request starts, allowing back-to-back operations.
REQ-020 busy SHALL be high in RUN and FIX and low in IDLE and DONE.
REQ-021 The multiply result SHALL be the low WIDTH bits of the two's-complement product of the latched operands.
REQ-022 The divide result SHALL be the quotient truncated toward zero; no remainder is output.
REQ-023 A divisor of 0 SHALL set data_result to 0 and data_exception to 1.
REQ-024 A divide by zero SHALL be detected at E0 and skip RUN (IDLE->FIX->DONE), so data_resultRDY follows edge E0+2.
REQ-025 The quotient of -2^(WIDTH-1)/-1 SHALL be -2^(WIDTH-1) with data_exception set to 0.
REQ-026 data_result and data_exception SHALL hold their values from one DONE until the next FIX updates them.
REQ-027 Operand input changes after E0 SHALL NOT affect the operation in flight.

Reset
REQ-028 clr high SHALL immediately force the FSM to IDLE and set data_result=0, data_exception=0, data_resultRDY=0, busy=0 and the counter and operand registers to 0, including mid-operation.
REQ-029 An operation aborted by reset SHALL NOT produce a data_resultRDY pulse.
REQ-030 The first start edge SHALL be accepted on the first falling edge after clr deasserts.

Configuration
REQ-031 When macro MULTDIV_OVF_DETECT_EN is defined, FIX SHALL set data_exception=1 on multiply if the full 2*WIDTH-bit signed product is not representable in WIDTH signed bits.
REQ-032 When MULTDIV_OVF_DETECT_EN is not defined, a multiply SHALL always report data_exception=0 and the upper product bits SHALL NOT be stored.

Verification
REQ-033 A=7, B=-3, ctrl_MULT pulse -> data_resultRDY 33 edges later, data_result=-21, data_exception=0.
REQ-034 A=-100, B=7, ctrl_DIV pulse -> data_result=-14, data_exception=0; then B=0 -> data_result=0, data_exception=1 with data_resultRDY after 2 edges.
REQ-035 A=0x40000000, B=4, ctrl_MULT pulse -> data_result=0, with data_exception=1 if MULTDIV_OVF_DETECT_EN is defined and 0 otherwise.
REQ-036 clr pulsed at iteration 10 of a multiply -> all outputs 0 immediately and no data_resultRDY pulse within 40 edges.
REQ-037 ctrl_DIV pulsed during RUN of a multiply, then a new ctrl_MULT in DONE -> the divide is ignored and the second multiply completes 33 edges after its start.
REQ-038 ctrl_MULT and ctrl_DIV both high with A=6, B=3 -> data_result=18.
